// File: rtl/conv2_mac_scheduler.sv
// Conv layer 2 six-lane MAC sequencer: issues operand groups to the multiplier stage and
// accumulates returned products into one signed sum. CONV2_ZERO_SKIP_EN enables whole-group zero skipping.

module conv2_mac_lane #(
  parameter int PROD_W = 16,
  parameter int SUM_W  = 19
) (
  input  logic [PROD_W-1:0] prod,
  output logic [SUM_W-1:0]  prod_ext
);
  assign prod_ext = {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
endmodule

module conv2_mac_scheduler #(
  parameter int LANES  = 6,
  parameter int DATA_W = 8,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int GRP_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [GRP_W-1:0]        num_groups,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] feat_bus,
  input  logic [LANES*DATA_W-1:0] wgt_bus,
  output logic                    mul_enable,
  output logic [LANES*DATA_W-1:0] mul_feat,
  output logic [LANES*DATA_W-1:0] mul_wgt,
  input  logic                    mul_done,
  input  logic [LANES*PROD_W-1:0] mul_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic                    busy,
  output logic [GRP_W-1:0]        skip_cnt
);
  localparam int SUM_W = PROD_W + 3;
  localparam logic [GRP_W-1:0] MAX_GRP = GRP_W'(16);
  localparam logic [GRP_W-1:0] ONE     = GRP_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [GRP_W-1:0]           ngrp_q, ngrp_d, issued_q, issued_d;
  logic [GRP_W-1:0]           completed_q, completed_d, skip_q, skip_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [GRP_W-1:0]           ngrp_clamp;
  logic [LANES-1:0][SUM_W-1:0] lane_ext;
  logic [SUM_W-1:0]           lane_sum;
  logic                       grp_skip, accept, done_ok;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    conv2_mac_lane #(.PROD_W(PROD_W), .SUM_W(SUM_W)) u_lane (
      .prod     (mul_prod[g*PROD_W +: PROD_W]),
      .prod_ext (lane_ext[g])
    );
  end

`ifdef CONV2_ZERO_SKIP_EN
  logic [LANES-1:0] lane_zero;
  for (genvar g = 0; g < LANES; g++) begin : g_zero
    assign lane_zero[g] = (feat_bus[g*DATA_W +: DATA_W] == '0) ||
                          (wgt_bus[g*DATA_W +: DATA_W] == '0);
  end
  assign grp_skip = &lane_zero;
`else
  assign grp_skip = 1'b0;
`endif

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + lane_ext[i];
  end

  always_comb begin
    if (num_groups == '0)          ngrp_clamp = ONE;
    else if (num_groups > MAX_GRP) ngrp_clamp = MAX_GRP;
    else                           ngrp_clamp = num_groups;
  end

  assign mul_feat   = feat_bus;
  assign mul_wgt    = wgt_bus;
  assign mul_enable = accept && !grp_skip;
  assign out_sum    = acc_q;
  assign busy       = (state_q != IDLE);
  assign skip_cnt   = skip_q;

  always_comb begin
    state_d     = state_q;
    ngrp_d      = ngrp_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    skip_d      = skip_q;
    acc_d       = acc_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    done_ok     = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ngrp_d      = ngrp_clamp;
          issued_d    = '0;
          completed_d = '0;
          skip_d      = '0;
          acc_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        in_ready = (issued_q < ngrp_q);
        accept   = in_valid && in_ready;
        // A done with nothing outstanding is a stray pulse and must not touch the sum.
        done_ok  = mul_done && (completed_q != issued_q);
        if (accept) issued_d = issued_q + ONE;
        if (done_ok) begin
          acc_d       = acc_q + {{(ACC_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
          completed_d = completed_d + ONE;
        end
        if (accept && grp_skip) begin
          completed_d = completed_d + ONE;
          skip_d      = skip_q + ONE;
        end
        if (completed_d == ngrp_q) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ngrp_q      <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      skip_q      <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      ngrp_q      <= ngrp_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      skip_q      <= skip_d;
      acc_q       <= acc_d;
    end
  end
endmodule

// File: doc/conv2_mac_scheduler.md
# conv2_mac_scheduler

Sequencing controller for the Convolution Layer 2 six-lane multiplication stage. It accepts a convolution job (a count of 6-pair operand groups), streams groups from an upstream valid/ready source into the multiplier stage, and accumulates the six returned 16-bit products of every group into one signed partial sum. It then presents that sum downstream with a valid/ready handshake. It sits between the stage-1 output buffer and the stage-2 multiplier.

## Interface
- LANES, 6, multiplier lanes per group (fixed by the stage)
- DATA_W, 8, operand width
- PROD_W, 16, product width returned by the stage
- ACC_W, 24, accumulator and result width (signed)
- GRP_W, 5, width of the job group count (max 16 groups)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job start pulse, sampled only in IDLE
- num_groups  in  GRP_W  groups in job, latched on start; 0 is treated as 1, values above 16 are clamped to 16
- in_valid  in  1  upstream group valid
- in_ready  out  1  scheduler can accept a group
- feat_bus  in  LANES*DATA_W  six feature operands, lane 0 in LSBs
- wgt_bus  in  LANES*DATA_W  six weight operands, lane 0 in LSBs
- mul_enable  out  1  drives the stage enable
- mul_feat / mul_wgt  out  LANES*DATA_W  operands to the stage (pass-through of feat_bus/wgt_bus)
- mul_done  in  1  stage done flag
- mul_prod  in  LANES*PROD_W  signed products from the stage
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  ACC_W  signed accumulated result
- busy  out  1  high in any state but IDLE
- skip_cnt  out  GRP_W  groups skipped in the current/last job

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0, mul_enable=0. start=1 latches the count, clears acc, issued, completed and skip_cnt, and moves to RUN.
- RUN:
  - in_ready=1 while issued<num_groups.
  - On accept (in_valid&&in_ready), issued increments.
  - mul_enable = accept (combinational). Operands pass through unregistered.
- Completion: every cycle with mul_done=1, acc += sign-extend(sum of the six mul_prod lanes). The 19-bit lane sum is sign-extended to ACC_W, and completed increments by 1.
- Accumulation wraps modulo 2^ACC_W. No saturation is applied; 24 bits cannot overflow for 16 groups.
- RUN moves to DONE when the updated completed equals num_groups.
- DONE:
  - out_valid=1 and out_sum=acc, held stable until out_ready=1.
  - On out_valid&&out_ready the block returns to IDLE.
  - out_sum keeps its value after the handshake until the next start.
- start outside IDLE is ignored.
- mul_done arriving when completed==issued is ignored, with no acc change.

## Timing
- Reset values: in_ready=0, mul_enable=0, out_valid=0, out_sum=0, busy=0, skip_cnt=0, state IDLE.
- Reset is asynchronous. Asserting it mid-job aborts immediately with no result emitted.
- The stage has 1-cycle latency: accept in cycle T gives mul_done in T+1, and acc is updated at the end of T+1.
- Result latency: out_valid rises in T+2 after the last multiplied group is accepted.
- Back-to-back accepts sustain one group per cycle.
- Earliest next start is the cycle after the output handshake.

## Configuration
- Macro CONV2_ZERO_SKIP_EN controls operand gating of whole groups.
- Defined:
  - An accepted group is skipped when, in every lane, the feature or the weight is 0.
  - A skipped group leaves mul_enable at 0 and increments completed and skip_cnt in the accept cycle itself.
  - If a skip coincides with a mul_done from the previous group, completed increments by 2 that cycle.
  - If the last group is skipped, out_valid rises in T+1 (or when the outstanding mul_done lands, whichever is later).
- Undefined: no group is ever skipped, every accept pulses mul_enable, and skip_cnt is held at 0.

## Test plan
- num_groups=2. Group 0: all feat=0x01, wgt=0x02. Group 1: all feat=0xFF, wgt=0x03. Required: out_sum=0xFFFFFA (-6), with out_valid two cycles after the second accept.
- num_groups=16, all lanes 0x7F×0x7F, continuous in_valid. Required: in_ready high for 16 cycles, then out_sum=16·6·16129=1548384.
- Hold out_ready=0 for 5 cycles in DONE. Required: out_valid and out_sum stable. A start pulse during this time is ignored.
- Assert rst_n=0 in the cycle after the third of 4 accepts. Required: all outputs return to their reset values at once, and the next start runs cleanly.
- With CONV2_ZERO_SKIP_EN defined: num_groups=3, group 1 all-zero weights, others 1×1.
  - Required: mul_enable pulses twice, skip_cnt=1, out_sum=12.
  - Without the macro, mul_enable pulses three times and out_sum=12.
- num_groups=0 with a single 2×2 group. Required: treated as 1 group, out_sum=24.
